// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame scheduler: FSM encoding and default sizes.
package audio_pkg;

  localparam int unsigned DEF_SAMPLE_W  = 16;
  localparam int unsigned DEF_FRAME_LEN = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

endpackage

// File: rtl/audio_frame_scheduler_bank_tracker.sv
// Tracks which ping-pong banks hold a finished frame and which one the CPU reads next.
// An ack frees its bank before a same-cycle completion looks for a free bank.
module bank_tracker (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_init,
  input  logic       i_clr,
  input  logic       i_ack,
  input  logic       i_complete,
  input  logic       i_wr_bank,
  output logic [1:0] o_full,
  output logic       o_rd_bank,
  output logic       o_ack_take_c,
  output logic       o_other_free_c
);

  logic [1:0] r_full;
  logic       r_rd_bank;
  logic [1:0] w_full_acked;
  logic [1:0] w_full_set;

  // Ack is honoured only when the bank it targets actually holds a frame.
  assign o_ack_take_c   = i_ack && r_full[r_rd_bank];
  assign w_full_acked   = r_full & ~(2'(o_ack_take_c) << r_rd_bank);
  assign w_full_set     = 2'(i_complete) << i_wr_bank;
  assign o_other_free_c = !w_full_acked[~i_wr_bank];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_init) begin
      r_full    <= 2'b00;
      r_rd_bank <= 1'b0;
    end else begin
      r_full    <= i_clr ? 2'b00 : (w_full_acked | w_full_set);
      r_rd_bank <= r_rd_bank ^ o_ack_take_c;
    end
  end

  assign o_full    = r_full;
  assign o_rd_bank = r_rd_bank;

endmodule

// File: rtl/audio_frame_scheduler.sv
// Gates the I2S receiver and packs samples into ping-pong frames of the sample RAM,
// handing full banks to the CPU and flagging samples dropped while both banks are full.
module audio_frame_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          cfg_enable,
  input  logic                          s_valid,
  input  logic [SAMPLE_W-1:0]           s_data,
  input  logic                          frame_ack,
  input  logic                          overrun_clr,
  output logic                          i2s_en,
  output logic                          mem_we,
  output logic [$clog2(FRAME_LEN):0]    mem_addr,
  output logic [SAMPLE_W-1:0]           mem_wdata,
  output logic                          frame_ready,
  output logic                          rd_bank,
  output logic                          overrun,
  output logic [15:0]                   frame_count
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);

  state_t              r_state,       w_state_nxt;
  logic                r_wr_bank,     w_wr_bank_nxt;
  logic [IDX_W-1:0]    r_wr_idx,      w_wr_idx_nxt;
  logic                r_i2s_en;
  logic                r_mem_we,      w_mem_we_nxt;
  logic [IDX_W:0]      r_mem_addr,    w_mem_addr_nxt;
  logic [SAMPLE_W-1:0] r_mem_wdata,   w_mem_wdata_nxt;
  logic                r_overrun,     w_overrun_nxt;
  logic [15:0]         r_frame_count, w_frame_count_nxt;

  logic       w_init;
  logic       w_clr;
  logic       w_complete;
  logic [1:0] w_full;
  logic       w_rd_bank;
  logic       w_ack_take;
  logic       w_other_free;

  bank_tracker u_bank_tracker (
    .i_clk          (HCLK),
    .i_rst          (HRESET),
    .i_init         (w_init),
    .i_clr          (w_clr),
    .i_ack          (frame_ack),
    .i_complete     (w_complete),
    .i_wr_bank      (r_wr_bank),
    .o_full         (w_full),
    .o_rd_bank      (w_rd_bank),
    .o_ack_take_c   (w_ack_take),
    .o_other_free_c (w_other_free)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state       <= ST_IDLE;
      r_wr_bank     <= 1'b0;
      r_wr_idx      <= '0;
      r_i2s_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_bank     <= w_wr_bank_nxt;
      r_wr_idx      <= w_wr_idx_nxt;
      r_i2s_en      <= (w_state_nxt != ST_IDLE);
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_overrun     <= w_overrun_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wr_bank_nxt     = r_wr_bank;
    w_wr_idx_nxt      = r_wr_idx;
    w_mem_we_nxt      = 1'b0;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_overrun_nxt     = overrun_clr ? 1'b0 : r_overrun;
    w_frame_count_nxt = r_frame_count;
    w_init            = 1'b0;
    w_clr             = 1'b0;
    w_complete        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cfg_enable) begin
          w_state_nxt       = ST_FILL;
          w_wr_bank_nxt     = 1'b0;
          w_wr_idx_nxt      = '0;
          w_frame_count_nxt = '0;
          w_init            = 1'b1;
        end
      end
      ST_FILL: begin
        if (!cfg_enable) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else if (s_valid) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = {r_wr_bank, r_wr_idx};
          w_mem_wdata_nxt = s_data;
          if (r_wr_idx == IDX_W'(FRAME_LEN - 1)) begin
            w_complete        = 1'b1;
            w_frame_count_nxt = r_frame_count + 16'd1;
            w_wr_idx_nxt      = '0;
            // Other bank free (possibly via this cycle's ack): ping-pong; else wait for the CPU.
            if (w_other_free) w_wr_bank_nxt = ~r_wr_bank;
            else              w_state_nxt   = ST_STALL;
          end else begin
            w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
          end
        end
      end
      ST_STALL: begin
        if (s_valid) w_overrun_nxt = 1'b1;
        if (!cfg_enable) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else if (w_ack_take) begin
          w_state_nxt   = ST_FILL;
          w_wr_bank_nxt = w_rd_bank;
          w_wr_idx_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign i2s_en      = r_i2s_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign frame_ready = w_full[0] | w_full[1];
  assign rd_bank     = w_rd_bank;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Scoreboard bench for audio_frame_scheduler: directed scenarios then randomized traffic
// checked against a frame-level model (pending-frame count, ack count, sample index).
module tb_audio_frame_scheduler;

  localparam int unsigned SW = 16;
  localparam int unsigned FL = 4;
  localparam int unsigned AW = 3;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          cfg_enable;
  logic          s_valid;
  logic [SW-1:0] s_data;
  logic          frame_ack;
  logic          overrun_clr;
  logic          i2s_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata;
  logic          frame_ready;
  logic          rd_bank;
  logic          overrun;
  logic [15:0]   frame_count;

  always #5 HCLK = ~HCLK;

  audio_frame_scheduler #(.SAMPLE_W(SW), .FRAME_LEN(FL)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .cfg_enable  (cfg_enable),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .frame_ack   (frame_ack),
    .overrun_clr (overrun_clr),
    .i2s_en      (i2s_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .frame_ready (frame_ready),
    .rd_bank     (rd_bank),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level model: banks are written in order, read in order.
  bit m_run;
  int m_pending;
  int m_acks;
  int m_idx;
  int m_cnt;
  bit m_ovr;
  bit m_we;
  logic [AW+SW-1:0] exp_q[$];
  logic mon_en = 1'b0;
  logic [15:0] sample_ctr = 16'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pending = 0; m_acks = 0; m_idx = 0; m_cnt = 0; m_ovr = 0; m_we = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit en, input bit sv, input logic [SW-1:0] d,
                            input bit ack, input bit clr);
    bit set_ovr;
    bit stalled;
    int bank;
    set_ovr = 0;
    m_we    = 0;
    if (!m_run) begin
      if (en) begin
        m_run = 1; m_pending = 0; m_acks = 0; m_idx = 0; m_cnt = 0;
      end
    end else begin
      stalled = (m_pending == 2);
      bank    = (m_acks + m_pending) % 2;
      if (stalled && sv) set_ovr = 1;
      if (!en) begin
        m_run = 0;
        if (ack && m_pending > 0) m_acks++;
        m_pending = 0;
        m_idx = 0;
      end else begin
        if (ack && m_pending > 0) begin
          m_pending--;
          m_acks++;
        end
        if (!stalled && sv) begin
          m_we = 1;
          exp_q.push_back({AW'(bank * FL + m_idx), d});
          m_idx++;
          if (m_idx == FL) begin
            m_idx = 0;
            m_cnt = (m_cnt + 1) % 65536;
            m_pending++;
          end
        end
      end
    end
    m_ovr = set_ovr ? 1'b1 : (clr ? 1'b0 : m_ovr);
  endtask

  task automatic cycle(input bit en, input bit sv, input bit ack, input bit clr, input bit rst);
    logic [SW-1:0] d;
    d = sv ? sample_ctr : SW'($urandom);
    HRESET = rst; cfg_enable = en; s_valid = sv; s_data = d; frame_ack = ack; overrun_clr = clr;
    @(posedge HCLK);
    if (sv) sample_ctr = sample_ctr + 16'd1;
    if (rst) model_reset();
    else     model_step(en, sv, d, ack, clr);
    @(negedge HCLK);
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each RAM write.
  always @(negedge HCLK) begin
    logic [AW+SW-1:0] e;
    if (mon_en) begin
      chk("i2s_en", 32'(i2s_en), 32'(m_run));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("frame_ready", 32'(frame_ready), 32'(m_pending > 0));
      chk("rd_bank", 32'(rd_bank), 32'(m_acks % 2));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("frame_count", 32'(frame_count), 32'(m_cnt));
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected addr=%0h data=%0h t=%0t", mem_addr, mem_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(e[AW+SW-1:SW]));
          chk("mem_wdata", 32'(mem_wdata), 32'(e[SW-1:0]));
        end
      end
    end
  end

  initial begin
    bit en, sv, ack, clr;
    int ack_pct;
    HRESET = 1; cfg_enable = 0; s_valid = 0; s_data = '0; frame_ack = 0; overrun_clr = 0;
    model_reset();
    mon_en = 1'b1;

    // Reset held three cycles; all outputs zero.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    cycle(1, 0, 0, 0, 0);
    // First frame into bank 0, then bank 1 fills and the scheduler stalls.
    samples(4);
    samples(4);
    cycle(1, 1, 0, 0, 0);              // dropped, overrun
    cycle(1, 0, 1, 0, 0);              // frees bank 0
    samples(3);
    cycle(1, 1, 1, 0, 0);              // last sample of bank 0 with ack of bank 1
    samples(1);
    samples(1);
    cycle(0, 0, 0, 0, 0);              // disable mid-frame
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);              // re-enable
    samples(1);
    cycle(1, 0, 1, 0, 0);              // ack with nothing full
    samples(11);                       // fill both banks, stall
    cycle(1, 1, 0, 1, 0);              // drop and clear together: overrun stays set
    cycle(1, 0, 0, 1, 0);              // clear alone
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);

    // Randomized traffic with phases of fast and slow CPU acks.
    for (int i = 0; i < 3000; i++) begin
      ack_pct = ((i / 300) % 2 == 0) ? 4 : 30;
      en  = ($urandom_range(0, 99) >= 2);
      sv  = ($urandom_range(0, 99) < 55);
      ack = ($urandom_range(0, 99) < ack_pct);
      clr = ($urandom_range(0, 99) < 5);
      if (!en) begin
        sv = 0;
        ack = 0;
      end
      cycle(en, sv, ack, clr, (i == 1700));
    end

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
